// File: rtl/rp_8bit_io_timer.sv
// 8-bit timer/counter responder on the rp_8bit I/O bus: a five-register window,
// a 10-bit prescaler, overflow / compare-match flags and level interrupt requests.
module rp_8bit_io_timer #(
    parameter logic [5:0] BASE = 6'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       io_wen,
    input  logic       io_ren,
    input  logic [5:0] io_adr,
    input  logic [7:0] io_wdt,
    input  logic [7:0] io_msk,
    output logic [7:0] io_rdt,
    output logic [1:0] irq_req,
    input  logic [1:0] irq_ack
);

    localparam logic [2:0] OFF_TCNT  = 3'd0;
    localparam logic [2:0] OFF_OCR   = 3'd1;
    localparam logic [2:0] OFF_TCCR  = 3'd2;
    localparam logic [2:0] OFF_TIMSK = 3'd3;
    localparam logic [2:0] OFF_TIFR  = 3'd4;

    // architectural state
    logic [7:0] tcnt;
    logic [7:0] ocr;
    logic       ctc;
    logic [2:0] cs;
    logic       ocie;
    logic       toie;
    logic       ocf;
    logic       tov;
    logic [9:0] pre;

    // bus decode
    logic [5:0] rel_adr;
    logic       in_win;
    logic [2:0] off;
    logic [7:0] wbits;
    logic       wr_tcnt;
    logic       wr_ocr;
    logic       wr_tccr;
    logic       wr_timsk;
    logic       wr_tifr;
    logic [7:0] rd_val;

    // count / flag control
    logic       pre_run;
    logic       tick;
    logic       psr;
    logic       match;
    logic       cnt_tick;
    logic       ctc_clear;
    logic       set_ocf;
    logic       set_tov;
    logic       clr_ocf;
    logic       clr_tov;
    logic       ctc_new;
    logic [2:0] cs_new;
    logic       ocie_new;
    logic       toie_new;

    // An address below BASE wraps to a large offset, so one compare covers both ends.
    assign rel_adr = io_adr - BASE;
    assign in_win  = (rel_adr < 6'd5);
    assign off     = rel_adr[2:0];
    assign wbits   = io_wdt & io_msk;

    assign wr_tcnt  = io_wen && in_win && (off == OFF_TCNT);
    assign wr_ocr   = io_wen && in_win && (off == OFF_OCR);
    assign wr_tccr  = io_wen && in_win && (off == OFF_TCCR);
    assign wr_timsk = io_wen && in_win && (off == OFF_TIMSK);
    assign wr_tifr  = io_wen && in_win && (off == OFF_TIFR);

    assign ctc_new  = wbits[3] | (ctc & ~io_msk[3]);
    assign cs_new   = wbits[2:0] | (cs & ~io_msk[2:0]);
    assign ocie_new = wbits[1] | (ocie & ~io_msk[1]);
    assign toie_new = wbits[0] | (toie & ~io_msk[0]);
    assign psr      = wr_tccr && wbits[4];

    assign pre_run = (cs != 3'd0) && (cs < 3'd6);

    // NOTE: every signal assigned in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        tick = 1'b0;
        case (cs)
            3'd1:    tick = 1'b1;
            3'd2:    tick = &pre[2:0];
            3'd3:    tick = &pre[5:0];
            3'd4:    tick = &pre[7:0];
            3'd5:    tick = &pre;
            default: tick = 1'b0;
        endcase
    end

    // A CPU write to TCNT swallows the tick entirely, including its flags.
    assign match     = (tcnt == ocr);
    assign cnt_tick  = tick && !wr_tcnt;
    assign ctc_clear = ctc && match;
    assign set_ocf   = cnt_tick && match;
    assign set_tov   = cnt_tick && !ctc_clear && (tcnt == 8'hff);
    assign clr_ocf   = irq_ack[1] | (wr_tifr && wbits[1]);
    assign clr_tov   = irq_ack[0] | (wr_tifr && wbits[0]);

    always_comb begin
        rd_val = 8'h00;
        if (in_win) begin
            case (off)
                OFF_TCNT:  rd_val = tcnt;
                OFF_OCR:   rd_val = ocr;
                OFF_TCCR:  rd_val = {4'b0000, ctc, cs};
                OFF_TIMSK: rd_val = {6'b000000, ocie, toie};
                OFF_TIFR:  rd_val = {6'b000000, ocf, tov};
                default:   rd_val = 8'h00;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every block samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= 10'd0;
        end else if (psr) begin
            pre <= 10'd0;
        end else if (pre_run) begin
            pre <= pre + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= 8'h00;
        end else if (wr_tcnt) begin
            tcnt <= wbits | (tcnt & ~io_msk);
        end else if (tick) begin
            tcnt <= ctc_clear ? 8'h00 : tcnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ocr  <= 8'h00;
            ctc  <= 1'b0;
            cs   <= 3'd0;
            ocie <= 1'b0;
            toie <= 1'b0;
        end else begin
            if (wr_ocr) begin
                ocr <= wbits | (ocr & ~io_msk);
            end
            if (wr_tccr) begin
                ctc <= ctc_new;
                cs  <= cs_new;
            end
            if (wr_timsk) begin
                ocie <= ocie_new;
                toie <= toie_new;
            end
        end
    end

    // Setting a flag beats any clear arriving on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ocf <= 1'b0;
            tov <= 1'b0;
        end else begin
            ocf <= set_ocf | (ocf & ~clr_ocf);
            tov <= set_tov | (tov & ~clr_tov);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_rdt <= 8'h00;
        end else if (io_ren) begin
            io_rdt <= rd_val;
        end
    end

    assign irq_req = {ocf & ocie, tov & toie};

endmodule
